// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Grant encoding doubles as the round-robin history bit.
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard with set-over-clear priority.
// Busy also covers the register currently sitting in the write stage.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int REG_COUNT = regfile_wb_arbiter_pkg::REG_COUNT,
    parameter int ADDR_W    = regfile_wb_arbiter_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    logic [REG_COUNT-1:0] sb;
    logic [REG_COUNT-1:0] sb_next;

    always_comb begin
        sb_next = sb;
        if (clr_en) begin
            sb_next[clr_rd] = 1'b0;
        end
        if (set_en) begin
            sb_next[set_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // Data in the write stage is not yet visible in register_file.
    assign rs1_busy = sb[rs1] |
                      (wb_we && (wb_rd == rs1) && (rs1 != '0));
    assign rs2_busy = sb[rs2] |
                      (wb_we && (wb_rd == rs2) && (rs2 != '0));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/LSU writeback arbiter driving the register_file
// write port, plus the pending-load scoreboard used by decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN      = regfile_wb_arbiter_pkg::XLEN,
    parameter int REG_COUNT = regfile_wb_arbiter_pkg::REG_COUNT,
    parameter int ADDR_W    = regfile_wb_arbiter_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_di3,
    output logic              rf_we3
);

    grant_t last_grant;
    logic   conflict;
    logic   alu_xfer;
    logic   lsu_xfer;

    assign conflict  = alu_valid && lsu_valid;

    // On conflict the requester that did not win last time goes first.
    assign alu_ready = reset && alu_valid &&
                       (!lsu_valid || (last_grant == GRANT_LSU));
    assign lsu_ready = reset && lsu_valid &&
                       (!alu_valid || (last_grant == GRANT_ALU));

    assign alu_xfer  = alu_valid && alu_ready;
    assign lsu_xfer  = lsu_valid && lsu_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= GRANT_ALU;
            rf_a3      <= '0;
            rf_di3     <= '0;
            rf_we3     <= 1'b0;
        end else begin
            if (conflict) begin
                last_grant <= alu_xfer ? GRANT_ALU : GRANT_LSU;
            end
            if (alu_xfer) begin
                rf_a3  <= alu_rd;
                rf_di3 <= alu_data;
                rf_we3 <= (alu_rd != '0);
            end else if (lsu_xfer) begin
                rf_a3  <= lsu_rd;
                rf_di3 <= lsu_data;
                rf_we3 <= (lsu_rd != '0);
            end else begin
                rf_we3 <= 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_valid && (issue_rd != '0)),
        .set_rd   (issue_rd),
        .clr_en   (lsu_xfer),
        .clr_rd   (lsu_rd),
        .wb_we    (rf_we3),
        .wb_rd    (rf_a3),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule
